// File: rtl/nn_key_port.sv
// -----------------------------------------------------------------------------
// nn_key_port -- memory-mapped KEY input responder for nnRvSoc.
//
// The raw key pins are synchronised and debounced, and their debounced level is
// reported. A press sets an event bit that stays set until software writes a 1
// to it. IRQ is raised while any unmasked event bit is set.
//
// Register map (byte offsets from BASE_ADDR, address bits [1:0] ignored):
//   0x0 STATE  RO   {0, key_state}     stores respond but change nothing
//   0x8 EVENT  W1C  sticky event bits   a new event wins over a clear in the same cycle
//   0xC MASK   RW   IRQ enable per event bit
//   Any other offset gets no response.
//
// Optional feature: define KEY_RELEASE_EVT_EN to widen EVENT/MASK to 2*KEY_W.
// The upper half then records release (pressed -> not pressed) events.
//
// Ports:
//   clk_i        system clock (single domain)
//   rst_i        synchronous reset, active-high
//   key_i        raw asynchronous key pins
//   req_valid_i  bus request strobe, one cycle per access
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address
//   req_wdata_i  store data
//   rsp_valid_o  one-cycle pulse one cycle after a request that hit this block
//   rsp_rdata_o  load data, valid with rsp_valid_o (0 for stores)
//   key_state_o  debounced pressed level per key
//   irq_o        registered |(EVENT & MASK)
// -----------------------------------------------------------------------------
module nn_key_port #(
  parameter int          KEY_W          = 4,
  parameter int          DEB_CYCLES     = 16,
  parameter int          KEY_ACTIVE_LOW = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [KEY_W-1:0]  key_state_o,
  output logic              irq_o
);

  localparam int CW = $clog2(DEB_CYCLES);
`ifdef KEY_RELEASE_EVT_EN
  localparam int EW = 2 * KEY_W;
`else
  localparam int EW = KEY_W;
`endif

  // ---------------------------------------------------------------------------
  // Input path. Polarity is applied in front of the synchroniser so that every
  // flop holds "pressed" and the all-zero reset value means "not pressed".
  // Otherwise an active-low idle key would look pressed for the two cycles the
  // synchroniser needs to refill after reset.
  // ---------------------------------------------------------------------------
  logic [KEY_W-1:0] key_pressed;
  logic [KEY_W-1:0] sync1_q, sync2_q;
  logic [KEY_W-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [KEY_W];
  logic [CW-1:0]    cnt_d [KEY_W];

  assign key_pressed = (KEY_ACTIVE_LOW != 0) ? ~key_i : key_i;

  generate
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_deb
      logic differ;
      logic cnt_done;
      assign differ   = sync2_q[gi] ^ stable_q[gi];
      assign cnt_done = (cnt_q[gi] == CW'(DEB_CYCLES - 1));
      // The counter only runs while the synchronised level disagrees with the
      // stable level. Any reversal clears it, so a level must hold for
      // DEB_CYCLES consecutive cycles before it is accepted.
      assign cnt_d[gi]    = (!differ || cnt_done) ? '0 : cnt_q[gi] + 1'b1;
      assign stable_d[gi] = (differ && cnt_done) ? sync2_q[gi] : stable_q[gi];
    end
  endgenerate

  logic [KEY_W-1:0] rise, fall;
  logic [EW-1:0]    evt_set;

  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

`ifdef KEY_RELEASE_EVT_EN
  assign evt_set = {fall, rise};
`else
  assign evt_set = rise;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode. The offset is a word offset, so address bits [1:0] play no role.
  // ---------------------------------------------------------------------------
  logic [29:0] word_off;
  logic        hit_state, hit_event, hit_mask, hit_any;
  logic        wr_event, wr_mask;
  logic [31:0] rd_mux;

  logic [EW-1:0] event_q, event_d;
  logic [EW-1:0] mask_q, mask_d;
  logic [EW-1:0] evt_clr;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          irq_q;

  assign word_off  = req_addr_i[31:2] - BASE_ADDR[31:2];
  assign hit_state = req_valid_i && (word_off == 30'd0);
  assign hit_event = req_valid_i && (word_off == 30'd2);
  assign hit_mask  = req_valid_i && (word_off == 30'd3);
  assign hit_any   = hit_state || hit_event || hit_mask;
  assign wr_event  = hit_event && req_we_i;
  assign wr_mask   = hit_mask && req_we_i;

  // Load data comes from the current register contents, so a load sees the
  // state from before any update made in the same cycle.
  always_comb begin
    rd_mux = '0;
    if (hit_state)      rd_mux = 32'(stable_q);
    else if (hit_event) rd_mux = 32'(event_q);
    else if (hit_mask)  rd_mux = 32'(mask_q);
  end

  assign evt_clr     = wr_event ? req_wdata_i[EW-1:0] : '0;
  // Clear first, then set, so a new event wins over a same-cycle clear.
  assign event_d     = (event_q & ~evt_clr) | evt_set;
  assign mask_d      = wr_mask ? req_wdata_i[EW-1:0] : mask_q;
  assign rsp_valid_d = hit_any;
  assign rsp_rdata_d = (hit_any && !req_we_i) ? rd_mux : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      event_q     <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < KEY_W; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= key_pressed;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      event_q     <= event_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      // IRQ follows EVENT/MASK one cycle later.
      irq_q       <= |(event_q & mask_q);
      for (int i = 0; i < KEY_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign key_state_o = stable_q;
  assign irq_o       = irq_q;

endmodule
